// File: rtl/matriz_pkg.sv
// ---------------------------------------------------------------------------
// matriz_pkg
// Shared definitions for the scrolling LED-matrix driver.
//   modo_t  : scroll mode as seen on the {ch1, ch0} switches
//   largura : counter/index width for a given range, never narrower than 1 bit
// ---------------------------------------------------------------------------
package matriz_pkg;

    // Scroll modes, encoded exactly as the switches present them: {ch1, ch0}.
    typedef enum logic [1:0] {
        MODO_HOLD = 2'b00,   // keep the current offset
        MODO_ESQ  = 2'b01,   // scroll left  (offset + 1)
        MODO_DIR  = 2'b10,   // scroll right (offset - 1)
        MODO_HOME = 2'b11    // return to offset 0
    } modo_t;

    // Bits needed to hold the values 0..n-1. A range of one value still gets
    // one bit so that declarations never collapse to a zero-width vector.
    function automatic int unsigned largura(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gerador_tick.sv
// ---------------------------------------------------------------------------
// gerador_tick
// Enabled modulo-DIV counter. Counts 0..DIV-1 on every enabled clock and
// raises tick_o for exactly one cycle when an enabled clock lands on the
// terminal count. Used both as the column-scan prescaler (always enabled)
// and as the frame counter (enabled by frame_tick).
//
// Ports
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active high; counter returns to 0
//   en_i   : count enable
//   tick_o : one-cycle pulse, en_i high while the counter holds DIV-1
// ---------------------------------------------------------------------------
module gerador_tick
    import matriz_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = largura(DIV);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         terminal;

    assign terminal = (cnt_q == W'(DIV - 1));
    assign tick_o   = en_i && terminal;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves it unassigned would otherwise infer a latch.
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = terminal ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matriz_scroll_param.sv
// ---------------------------------------------------------------------------
// matriz_scroll_param
// Column-multiplexed LED matrix driver with a scrolling message window.
// A message of MSG_LEN columns (LINHAS bits each) is held in a small
// register memory; COLUNAS consecutive columns starting at offset pos are
// scanned one at a time, each lit for SCAN_DIV clocks. Every SCROLL_FRAMES
// complete frames the offset moves according to the mode switches.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst            : asynchronous reset, active high
//   ch1, ch0       : asynchronous mode switches {ch1,ch0} (see modo_t)
//   wr_en          : message memory write strobe
//   wr_addr        : message column to write
//   wr_data        : column pattern, bit i drives row i
//   linhas         : registered row drive for the lit column, active high
//   acender_coluna : registered column select, one-hot low
//   pos            : current scroll offset
//   frame_tick     : one-cycle pulse as the last column's interval ends
// ---------------------------------------------------------------------------
module matriz_scroll_param
    import matriz_pkg::*;
#(
    parameter int LINHAS        = 5,
    parameter int COLUNAS       = 7,
    parameter int MSG_LEN       = 16,
    parameter int SCAN_DIV      = 50000,
    parameter int SCROLL_FRAMES = 50
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ch1,
    input  logic                       ch0,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [LINHAS-1:0]          wr_data,
    output logic [LINHAS-1:0]          linhas,
    output logic [COLUNAS-1:0]         acender_coluna,
    output logic [$clog2(MSG_LEN)-1:0] pos,
    output logic                       frame_tick
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int CW = largura(COLUNAS);

    // Column 0 is driven by the most significant select bit.
    localparam logic [COLUNAS-1:0] SEL_RESET = ~(COLUNAS'(1) << (COLUNAS - 1));

    // ------------------------------------------------------------------
    // Mode switch synchroniser
    // ------------------------------------------------------------------
    logic [1:0] ch_meta_q;
    logic [1:0] ch_sync_q;
    modo_t      modo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_meta_q <= 2'b00;
            ch_sync_q <= 2'b00;
        end else begin
            ch_meta_q <= {ch1, ch0};
            ch_sync_q <= ch_meta_q;
        end
    end

    assign modo = modo_t'(ch_sync_q);

    // ------------------------------------------------------------------
    // Timing chain: column prescaler, then frame counter
    // ------------------------------------------------------------------
    logic col_tick;
    logic scroll_step;

    logic [CW-1:0] col_q;
    logic [CW-1:0] col_d;
    logic          col_last;

    gerador_tick #(
        .DIV (SCAN_DIV)
    ) u_scan_div (
        .clk    (clk),
        .rst    (rst),
        .en_i   (1'b1),
        .tick_o (col_tick)
    );

    assign col_last   = (col_q == CW'(COLUNAS - 1));
    assign frame_tick = col_tick && col_last;

    gerador_tick #(
        .DIV (SCROLL_FRAMES)
    ) u_frame_div (
        .clk    (clk),
        .rst    (rst),
        .en_i   (frame_tick),
        .tick_o (scroll_step)
    );

    // ------------------------------------------------------------------
    // Message memory
    // ------------------------------------------------------------------
    logic [LINHAS-1:0] mem_q [MSG_LEN];
    logic              wr_ok;

    // Only meaningful when MSG_LEN is not a power of two.
    assign wr_ok = ({1'b0, wr_addr} < (AW + 1)'(MSG_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this memory is cleared by reset so a freshly reset display
            // is dark; that forces flops rather than a RAM macro, which is
            // acceptable at these message depths.
            for (int i = 0; i < MSG_LEN; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Next column, next offset, and the display values they select
    // ------------------------------------------------------------------
    logic [AW-1:0]      pos_q;
    logic [AW-1:0]      pos_d;
    logic [AW:0]        soma;
    logic [AW-1:0]      rd_addr;
    logic [COLUNAS-1:0] sel_d;

    always_comb begin
        col_d = col_q;
        if (col_tick) begin
            col_d = col_last ? '0 : col_q + 1'b1;
        end
    end

    // A step only ever coincides with the wrap to column 0, so the new
    // offset starts cleanly with the next frame.
    always_comb begin
        pos_d = pos_q;
        if (scroll_step) begin
            unique case (modo)
                MODO_HOLD: pos_d = pos_q;
                MODO_ESQ:  pos_d = (pos_q == AW'(MSG_LEN - 1)) ? '0 : pos_q + 1'b1;
                MODO_DIR:  pos_d = (pos_q == '0) ? AW'(MSG_LEN - 1) : pos_q - 1'b1;
                MODO_HOME: pos_d = '0;
            endcase
        end
    end

    // Rows and select are both derived from the *next* column and offset
    // so they load together on the column-tick edge and can never disagree.
    // pos < MSG_LEN and col < COLUNAS <= MSG_LEN, so one subtraction wraps.
    always_comb begin
        soma    = {1'b0, pos_d} + (AW + 1)'(col_d);
        rd_addr = soma[AW-1:0];
        if (soma >= (AW + 1)'(MSG_LEN)) begin
            rd_addr = AW'(soma - (AW + 1)'(MSG_LEN));
        end
    end

    always_comb begin
        for (int i = 0; i < COLUNAS; i++) begin
            sel_d[i] = (i != (COLUNAS - 1) - int'(col_d));
        end
    end

    // ------------------------------------------------------------------
    // Scan state and registered display outputs
    // ------------------------------------------------------------------
    logic [LINHAS-1:0]  linhas_q;
    logic [COLUNAS-1:0] acender_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            pos_q     <= '0;
            linhas_q  <= '0;
            acender_q <= SEL_RESET;
        end else begin
            col_q <= col_d;
            pos_q <= pos_d;
            // Memory is read only here, so a write to the lit column waits
            // for the next column update instead of changing mid-interval.
            if (col_tick) begin
                linhas_q  <= mem_q[rd_addr];
                acender_q <= sel_d;
            end
        end
    end

    assign linhas         = linhas_q;
    assign acender_coluna = acender_q;
    assign pos            = pos_q;

endmodule

// File: tb/tb_matriz_scroll_param.sv
// ---------------------------------------------------------------------------
// tb_matriz_scroll_param
// Scenario tasks for the scrolling matrix driver with a reference model that
// reasons in elapsed clock cycles since reset rather than in counters.
// ---------------------------------------------------------------------------
module tb_matriz_scroll_param;
    import matriz_pkg::*;

    localparam int LINHAS        = 5;
    localparam int COLUNAS       = 7;
    localparam int MSG_LEN       = 16;
    localparam int SCAN_DIV      = 4;
    localparam int SCROLL_FRAMES = 2;
    localparam int FRAME_T       = SCAN_DIV * COLUNAS;        // 28
    localparam int STEP_T        = FRAME_T * SCROLL_FRAMES;   // 56

    logic               clk = 1'b0;
    logic               rst;
    logic               ch1;
    logic               ch0;
    logic               wr_en;
    logic [3:0]         wr_addr;
    logic [LINHAS-1:0]  wr_data;
    logic [LINHAS-1:0]  linhas;
    logic [COLUNAS-1:0] acender_coluna;
    logic [3:0]         pos;
    logic               frame_tick;

    int checks = 0;
    int errors = 0;

    matriz_scroll_param #(
        .LINHAS        (LINHAS),
        .COLUNAS       (COLUNAS),
        .MSG_LEN       (MSG_LEN),
        .SCAN_DIV      (SCAN_DIV),
        .SCROLL_FRAMES (SCROLL_FRAMES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch1            (ch1),
        .ch0            (ch0),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .linhas         (linhas),
        .acender_coluna (acender_coluna),
        .pos            (pos),
        .frame_tick     (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Reference model: m_t is the number of clock edges since reset was
    // released; column, frame and step follow from it by division.
    // ------------------------------------------------------------------
    int                m_t;
    int                m_pos;
    logic [LINHAS-1:0] m_mem [MSG_LEN];
    logic [LINHAS-1:0] m_linhas;
    logic [1:0]        m_prev1;   // switches seen one edge ago
    logic [1:0]        m_prev2;   // switches seen two edges ago

    function automatic logic [COLUNAS-1:0] exp_sel(input int t);
        int                 col;
        logic [COLUNAS-1:0] v;
        col = (t / SCAN_DIV) % COLUNAS;
        v = '1;
        v[COLUNAS-1-col] = 1'b0;
        return v;
    endfunction

    function automatic logic exp_ft(input int t);
        return (t % FRAME_T) == (FRAME_T - 1);
    endfunction

    task automatic model_reset();
        m_t      = 0;
        m_pos    = 0;
        m_linhas = '0;
        m_prev1  = 2'b00;
        m_prev2  = 2'b00;
        for (int i = 0; i < MSG_LEN; i++) m_mem[i] = '0;
    endtask

    task automatic model_edge();
        int tn;
        tn = m_t + 1;
        // The switch value applied at a step is the one seen two edges back.
        if (tn % STEP_T == 0) begin
            case (m_prev2)
                2'b01:   m_pos = (m_pos + 1) % MSG_LEN;
                2'b10:   m_pos = (m_pos + MSG_LEN - 1) % MSG_LEN;
                2'b11:   m_pos = 0;
                default: ;
            endcase
        end
        if (tn % SCAN_DIV == 0) begin
            m_linhas = m_mem[(m_pos + (tn / SCAN_DIV) % COLUNAS) % MSG_LEN];
        end
        if (wr_en && int'(wr_addr) < MSG_LEN) m_mem[wr_addr] = wr_data;
        m_prev2 = m_prev1;
        m_prev1 = {ch1, ch0};
        m_t     = tn;
    endtask

    // One clock: model follows the rising edge, caller resumes at the
    // falling edge where it samples outputs and drives new inputs.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 5000 && m_t < target; i++) cycle();
        if (m_t < target) begin
            errors++;
            $display("FAIL run_to: reached t=%0d, required t=%0d", m_t, target);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        {ch1, ch0} = MODO_HOLD;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic load_message();
        for (int k = 0; k < MSG_LEN; k++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(k);
            wr_data = 5'(k);
            cycle();
        end
        wr_en = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst     = 1'b1;
        model_reset();
        wr_en   = 1'b1;            // must be ignored while in reset
        wr_addr = 4'd3;
        wr_data = 5'b11111;
        {ch1, ch0} = MODO_HOME;
        cycle();
        cycle();
        checks++; if (linhas !== 5'b00000) begin errors++; $display("FAIL reset_linhas got=%b exp=00000", linhas); end
        checks++; if (acender_coluna !== 7'b0111111) begin errors++; $display("FAIL reset_sel got=%b exp=0111111", acender_coluna); end
        checks++; if (pos !== 4'd0) begin errors++; $display("FAIL reset_pos got=%0d exp=0", pos); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft got=%b exp=0", frame_tick); end
        wr_en = 1'b0;
        {ch1, ch0} = MODO_HOLD;
        rst = 1'b0;
    endtask

    task automatic test_scan();
        for (int k = 0; k < 2 * FRAME_T + 4; k++) begin
            checks++; if (acender_coluna !== exp_sel(m_t)) begin errors++; $display("FAIL scan_sel t=%0d got=%b exp=%b", m_t, acender_coluna, exp_sel(m_t)); end
            checks++; if (frame_tick !== exp_ft(m_t)) begin errors++; $display("FAIL scan_ft t=%0d got=%b exp=%b", m_t, frame_tick, exp_ft(m_t)); end
            checks++; if (linhas !== 5'b00000) begin errors++; $display("FAIL scan_linhas t=%0d got=%b exp=00000", m_t, linhas); end
            checks++; if (pos !== 4'd0) begin errors++; $display("FAIL scan_pos t=%0d got=%0d exp=0", m_t, pos); end
            cycle();
        end
    endtask

    task automatic test_scroll_left();
        do_reset();
        {ch1, ch0} = MODO_ESQ;
        load_message();
        run_to(STEP_T + 2);
        checks++; if (pos !== 4'd1) begin errors++; $display("FAIL left_first_step got=%0d exp=1", pos); end
        run_to(15 * STEP_T + 1);
        checks++; if (pos !== 4'd15) begin errors++; $display("FAIL left_pos15 got=%0d exp=15", pos); end
        checks++; if (linhas !== 5'b01111) begin errors++; $display("FAIL left_pos15_col0 got=%b exp=01111", linhas); end
        run_to(15 * STEP_T + SCAN_DIV + 1);
        checks++; if (acender_coluna !== 7'b1011111) begin errors++; $display("FAIL left_pos15_sel1 got=%b exp=1011111", acender_coluna); end
        checks++; if (linhas !== 5'b00000) begin errors++; $display("FAIL left_pos15_col1 got=%b exp=00000", linhas); end
        run_to(16 * STEP_T + 1);
        checks++; if (pos !== 4'd0) begin errors++; $display("FAIL left_wrap got=%0d exp=0", pos); end
        run_to(16 * STEP_T + SCAN_DIV + 1);
        checks++; if (linhas !== 5'b00001) begin errors++; $display("FAIL left_wrap_col1 got=%b exp=00001", linhas); end
    endtask

    task automatic test_scroll_right();
        do_reset();
        {ch1, ch0} = MODO_DIR;
        load_message();
        run_to(STEP_T - 1);
        checks++; if (pos !== 4'd0) begin errors++; $display("FAIL right_before_step got=%0d exp=0", pos); end
        run_to(STEP_T + 1);
        checks++; if (pos !== 4'd15) begin errors++; $display("FAIL right_wrap got=%0d exp=15", pos); end
        checks++; if (acender_coluna !== 7'b0111111) begin errors++; $display("FAIL right_sel0 got=%b exp=0111111", acender_coluna); end
        checks++; if (linhas !== 5'b01111) begin errors++; $display("FAIL right_col0 got=%b exp=01111", linhas); end
        run_to(STEP_T + SCAN_DIV + 1);
        checks++; if (linhas !== 5'b00000) begin errors++; $display("FAIL right_col1 got=%b exp=00000", linhas); end
    endtask

    task automatic test_mode_toggle();
        do_reset();
        {ch1, ch0} = MODO_ESQ;
        run_to(STEP_T + 2);
        checks++; if (pos !== 4'd1) begin errors++; $display("FAIL toggle_step1 got=%0d exp=1", pos); end
        run_to(70);  {ch1, ch0} = MODO_HOLD;
        run_to(90);  {ch1, ch0} = MODO_ESQ;
        run_to(2 * STEP_T + 2);
        checks++; if (pos !== 4'd2) begin errors++; $display("FAIL toggle_esq_at_step got=%0d exp=2", pos); end
        run_to(120); {ch1, ch0} = MODO_HOLD;
        run_to(140); {ch1, ch0} = MODO_ESQ;
        run_to(160); {ch1, ch0} = MODO_HOLD;
        run_to(3 * STEP_T - 1);
        checks++; if (pos !== 4'd2) begin errors++; $display("FAIL toggle_between_steps got=%0d exp=2", pos); end
        run_to(3 * STEP_T + 2);
        checks++; if (pos !== 4'd2) begin errors++; $display("FAIL toggle_hold_at_step got=%0d exp=2", pos); end
        {ch1, ch0} = MODO_HOME;
        run_to(4 * STEP_T + 2);
        checks++; if (pos !== 4'd0) begin errors++; $display("FAIL toggle_home got=%0d exp=0", pos); end
    endtask

    task automatic test_write_live();
        do_reset();
        run_to(2 * SCAN_DIV + 1);
        checks++; if (linhas !== 5'b00000) begin errors++; $display("FAIL live_before got=%b exp=00000", linhas); end
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 5'b11111;
        cycle();
        wr_en = 1'b0;
        checks++; if (acender_coluna !== 7'b1101111) begin errors++; $display("FAIL live_sel got=%b exp=1101111", acender_coluna); end
        checks++; if (linhas !== 5'b00000) begin errors++; $display("FAIL live_after_write got=%b exp=00000", linhas); end
        run_to(2 * SCAN_DIV + 3);
        checks++; if (linhas !== 5'b00000) begin errors++; $display("FAIL live_interval_end got=%b exp=00000", linhas); end
        run_to(3 * SCAN_DIV + 1);
        checks++; if (linhas !== 5'b00000) begin errors++; $display("FAIL live_next_col got=%b exp=00000", linhas); end
        run_to(FRAME_T + 2 * SCAN_DIV + 1);
        checks++; if (linhas !== 5'b11111) begin errors++; $display("FAIL live_next_frame got=%b exp=11111", linhas); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        {ch1, ch0} = MODO_ESQ;
        load_message();
        run_to(9 * STEP_T + 2);
        checks++; if (pos !== 4'd9) begin errors++; $display("FAIL mid_pos9 got=%0d exp=9", pos); end
        {ch1, ch0} = MODO_HOLD;
        run_to(9 * STEP_T + 10);
        checks++; if (linhas !== 5'b01011) begin errors++; $display("FAIL mid_before_rst got=%b exp=01011", linhas); end
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (pos !== 4'd0) begin errors++; $display("FAIL mid_rst_pos got=%0d exp=0", pos); end
        checks++; if (linhas !== 5'b00000) begin errors++; $display("FAIL mid_rst_linhas got=%b exp=00000", linhas); end
        checks++; if (acender_coluna !== 7'b0111111) begin errors++; $display("FAIL mid_rst_sel got=%b exp=0111111", acender_coluna); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL mid_rst_ft got=%b exp=0", frame_tick); end
        wr_en   = 1'b1;            // must be ignored while in reset
        wr_addr = 4'd3;
        wr_data = 5'b10101;
        cycle();
        cycle();
        wr_en = 1'b0;
        rst   = 1'b0;
        for (int k = 0; k < FRAME_T + 4; k++) begin
            checks++; if (acender_coluna !== exp_sel(m_t)) begin errors++; $display("FAIL mid_restart_sel t=%0d got=%b exp=%b", m_t, acender_coluna, exp_sel(m_t)); end
            checks++; if (linhas !== 5'b00000) begin errors++; $display("FAIL mid_cleared_mem t=%0d got=%b exp=00000", m_t, linhas); end
            cycle();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) {ch1, ch0} = 2'($urandom);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 4'($urandom);
            wr_data = 5'($urandom);
            cycle();
            checks++; if (linhas !== m_linhas) begin errors++; $display("FAIL rand_linhas t=%0d got=%b exp=%b", m_t, linhas, m_linhas); end
            checks++; if (acender_coluna !== exp_sel(m_t)) begin errors++; $display("FAIL rand_sel t=%0d got=%b exp=%b", m_t, acender_coluna, exp_sel(m_t)); end
            checks++; if (pos !== 4'(m_pos)) begin errors++; $display("FAIL rand_pos t=%0d got=%0d exp=%0d", m_t, pos, m_pos); end
            checks++; if (frame_tick !== exp_ft(m_t)) begin errors++; $display("FAIL rand_ft t=%0d got=%b exp=%b", m_t, frame_tick, exp_ft(m_t)); end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        ch1     = 1'b0;
        ch0     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_scan();
        test_scroll_left();
        test_scroll_right();
        test_mode_toggle();
        test_write_live();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
